// File: rtl/log_capture_multi_pkg.sv
// Shared definitions for the multi-channel capture logger: state encodings,
// default widths and the busy-state decode.
package log_capture_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

    localparam int DEF_NB_DATA  = 16;
    localparam int DEF_NB_ADDR  = 15;
    localparam int DEF_NB_CH    = 2;
    localparam int DEF_NB_SEL   = 1;
    localparam int DEF_NB_DECIM = 8;

    function automatic logic is_busy(input state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/log_capture_multi_ram.sv
// log_ram_sdp: simple-dual-port RAM, one write port and one registered read
// port; read-first on a same-address collision. No reset so it maps to BRAM.
module log_ram_sdp #(
    parameter int NB_WIDTH = 32,
    parameter int NB_ADDR  = 15
) (
    input  logic                clock,
    input  logic                i_wr_en,
    input  logic [NB_ADDR-1:0]  i_wr_addr,
    input  logic [NB_WIDTH-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0]  i_rd_addr,
    output logic [NB_WIDTH-1:0] o_rd_data
);

    logic [NB_WIDTH-1:0] mem_r [0:(2**NB_ADDR)-1];
    logic [NB_WIDTH-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; sees the pre-write contents on a collision.
    always_ff @(posedge clock) begin
        rd_data_r <= mem_r[i_rd_addr];
    end

    assign o_rd_data = rd_data_r;

endmodule

// File: rtl/log_capture_multi.sv
// log_capture_multi: logs NB_CH probe channels side by side into one BRAM with
// optional decimation. Define LOG_CAPTURE_TRIGGER_EN to add i_trigger and ARMED.
module log_capture_multi
    import log_capture_multi_pkg::*;
#(
    parameter int NB_DATA  = DEF_NB_DATA,
    parameter int NB_ADDR  = DEF_NB_ADDR,
    parameter int NB_CH    = DEF_NB_CH,
    parameter int NB_SEL   = DEF_NB_SEL,
    parameter int NB_DECIM = DEF_NB_DECIM
) (
    input  logic                     clock,
    input  logic                     in_reset,
    input  logic                     i_run,
    input  logic                     i_valid,
`ifdef LOG_CAPTURE_TRIGGER_EN
    input  logic                     i_trigger,
`endif
    input  logic [NB_CH*NB_DATA-1:0] i_data,
    input  logic [NB_DECIM-1:0]      i_decim,
    input  logic [NB_ADDR-1:0]       i_read_addr,
    input  logic [NB_SEL-1:0]        i_read_sel,
    output logic [NB_DATA-1:0]       o_read_data,
    output logic                     o_full,
    output logic                     o_busy
);

`ifdef LOG_CAPTURE_TRIGGER_EN
    localparam state_t RUN_STATE = ST_ARMED;
`else
    localparam state_t RUN_STATE = ST_CAPTURE;
`endif
    localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};

    state_t                   state_r, state_s;
    logic                     run_d_r;
    logic                     start_s;
    logic                     take_s;
    logic                     wr_en_s;
    logic [NB_ADDR-1:0]       wr_addr_r, wr_addr_s;
    logic [NB_DECIM-1:0]      decim_cnt_r, decim_cnt_s;
    logic [NB_DECIM-1:0]      decim_q_r, decim_q_s;
    logic                     full_r, full_s;
    logic                     busy_r;
    logic [NB_CH*NB_DATA-1:0] ram_q_s;
    logic [NB_SEL-1:0]        sel_d_r;
    logic [NB_DATA-1:0]       rd_word_s;
    logic [NB_DATA-1:0]       read_data_r;

    assign start_s = i_run & ~run_d_r;

    // Next-state, decimation and write-address logic.
    always_comb begin
        state_s     = state_r;
        wr_addr_s   = wr_addr_r;
        decim_cnt_s = decim_cnt_r;
        decim_q_s   = decim_q_r;
        full_s      = full_r;
        take_s      = 1'b0;
        wr_en_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                take_s = 1'b0;
            end
`ifdef LOG_CAPTURE_TRIGGER_EN
            ST_ARMED: begin
                if (!i_run) begin
                    state_s = ST_IDLE;
                    full_s  = 1'b0;
                end else if (i_valid && i_trigger) begin
                    state_s = ST_CAPTURE;
                    take_s  = 1'b1;
                end else begin
                    state_s = ST_ARMED;
                end
            end
`endif
            ST_CAPTURE: begin
                if (!i_run) begin
                    state_s = ST_IDLE;
                    full_s  = 1'b0;
                end else begin
                    take_s = i_valid;
                end
            end
            ST_FULL: begin
                state_s = ST_FULL;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A kept sample is written; the last address ends the run without wrapping.
        if (take_s) begin
            if (decim_cnt_r == {NB_DECIM{1'b0}}) begin
                wr_en_s     = 1'b1;
                wr_addr_s   = wr_addr_r + NB_ADDR'(1);
                decim_cnt_s = decim_q_r;
                if (wr_addr_r == ADDR_LAST) begin
                    state_s = ST_FULL;
                    full_s  = 1'b1;
                end else begin
                    full_s  = 1'b0;
                end
            end else begin
                decim_cnt_s = decim_cnt_r - NB_DECIM'(1);
            end
        end else begin
            wr_en_s = 1'b0;
        end

        // A start wins over everything else, after any write of this cycle.
        if (start_s) begin
            state_s     = RUN_STATE;
            wr_addr_s   = {NB_ADDR{1'b0}};
            decim_cnt_s = {NB_DECIM{1'b0}};
            decim_q_s   = i_decim;
            full_s      = 1'b0;
        end else begin
            decim_q_s   = decim_q_r;
        end
    end

    // Control registers.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            state_r     <= ST_IDLE;
            run_d_r     <= 1'b0;
            wr_addr_r   <= {NB_ADDR{1'b0}};
            decim_cnt_r <= {NB_DECIM{1'b0}};
            decim_q_r   <= {NB_DECIM{1'b0}};
            full_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            run_d_r     <= i_run;
            wr_addr_r   <= wr_addr_s;
            decim_cnt_r <= decim_cnt_s;
            decim_q_r   <= decim_q_s;
            full_r      <= full_s;
            busy_r      <= is_busy(state_s);
        end
    end

    log_ram_sdp #(
        .NB_WIDTH (NB_CH*NB_DATA),
        .NB_ADDR  (NB_ADDR)
    ) u_ram (
        .clock     (clock),
        .i_wr_en   (wr_en_s),
        .i_wr_addr (wr_addr_r),
        .i_wr_data (i_data),
        .i_rd_addr (i_read_addr),
        .o_rd_data (ram_q_s)
    );

    // Channel select; selects beyond NB_CH contribute nothing and read as zero.
    always_comb begin
        rd_word_s = {NB_DATA{1'b0}};
        for (int k = 0; k < NB_CH; k++) begin
            rd_word_s = rd_word_s |
                ((int'(sel_d_r) == k) ? ram_q_s[k*NB_DATA +: NB_DATA] : {NB_DATA{1'b0}});
        end
    end

    // Read mux pipeline: select is delayed to line up with the RAM register.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            sel_d_r     <= {NB_SEL{1'b0}};
            read_data_r <= {NB_DATA{1'b0}};
        end else begin
            sel_d_r     <= i_read_sel;
            read_data_r <= rd_word_s;
        end
    end

    assign o_read_data = read_data_r;
    assign o_full      = full_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_log_capture_multi.sv
// Scoreboard bench for log_capture_multi (NB_ADDR=4, NB_CH=2, NB_SEL=2).
// Builds with or without LOG_CAPTURE_TRIGGER_EN.
module tb_log_capture_multi;

    localparam int NB_DATA  = 16;
    localparam int NB_ADDR  = 4;
    localparam int NB_CH    = 2;
    localparam int NB_SEL   = 2;
    localparam int NB_DECIM = 8;

    logic                     clock = 1'b0;
    logic                     in_reset = 1'b1;
    logic                     i_run = 1'b0;
    logic                     i_valid = 1'b0;
`ifdef LOG_CAPTURE_TRIGGER_EN
    logic                     i_trigger = 1'b1;
`endif
    logic [NB_CH*NB_DATA-1:0] i_data = '0;
    logic [NB_DECIM-1:0]      i_decim = '0;
    logic [NB_ADDR-1:0]       i_read_addr = '0;
    logic [NB_SEL-1:0]        i_read_sel = '0;
    logic [NB_DATA-1:0]       o_read_data;
    logic                     o_full;
    logic                     o_busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    int          tag_q[$];
    logic rd_issue = 1'b0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;

    always #5 clock = ~clock;

    log_capture_multi #(
        .NB_DATA (NB_DATA), .NB_ADDR (NB_ADDR), .NB_CH (NB_CH),
        .NB_SEL (NB_SEL), .NB_DECIM (NB_DECIM)
    ) dut (
        .clock       (clock),
        .in_reset    (in_reset),
        .i_run       (i_run),
        .i_valid     (i_valid),
`ifdef LOG_CAPTURE_TRIGGER_EN
        .i_trigger   (i_trigger),
`endif
        .i_data      (i_data),
        .i_decim     (i_decim),
        .i_read_addr (i_read_addr),
        .i_read_sel  (i_read_sel),
        .o_read_data (o_read_data),
        .o_full      (o_full),
        .o_busy      (o_busy)
    );

    // Two-cycle read-latency tracker feeding the monitor.
    always @(posedge clock) begin
        p1 <= rd_issue;
        p2 <= p1;
    end

    // Monitor: compares each returned read word against the scoreboard.
    always @(negedge clock) begin
        logic [15:0] e;
        int t;
        if (p2) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow got=%h", o_read_data);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (o_read_data !== e) begin
                    failures++;
                    $display("FAIL rd_t%0d got=%h exp=%h", t, o_read_data, e);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input int s);
        logic [15:0] v;
        v = s[15:0];
        return {v ^ 16'h5A00, v};
    endfunction

    function automatic logic [15:0] ch1(input int s);
        logic [15:0] v;
        v = s[15:0];
        return v ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic rd(input int a, input int sel, input logic [15:0] e, input int tag);
        @(negedge clock);
        i_read_addr = a[NB_ADDR-1:0];
        i_read_sel  = sel[NB_SEL-1:0];
        rd_issue    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        @(negedge clock);
        rd_issue = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic start_run(input int decim);
        @(negedge clock);
        i_run   = 1'b0;
        i_valid = 1'b0;
        @(negedge clock);
        i_decim = decim[NB_DECIM-1:0];
        i_run   = 1'b1;
    endtask

    task automatic feed(input int s);
        @(negedge clock);
        i_valid = 1'b1;
        i_data  = mk(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_rdata", {16'd0, o_read_data}, 32'd0);
        in_reset = 1'b0;

        // 1: no decimation, ramp; full 17 edges after i_run rises
        start_run(0);
        for (int s = 0; s < 16; s++) begin
            feed(s);
            if (s == 0)  chk("t1_busy", {31'd0, o_busy}, 32'd1);
            if (s == 15) chk("t1_notfull", {31'd0, o_full}, 32'd0);
        end
        feed(16);
        chk("t1_full", {31'd0, o_full}, 32'd1);
        chk("t1_busy_off", {31'd0, o_busy}, 32'd0);
        feed(17);
        @(negedge clock);
        i_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd(a, 0, 16'(a), 1000 + a);
            rd(a, 1, ch1(a), 1100 + a);
        end
        rd(3, 2, 16'h0000, 1203);
        rd(15, 3, 16'h0000, 1315);
        drain();
        i_run = 1'b0;
        @(negedge clock);
        chk("t1_full_hold", {31'd0, o_full}, 32'd1);

        // 2: decimation by 4, i_decim change mid-run ignored
        start_run(3);
        for (int s = 0; s < 64; s++) begin
            feed(s);
            if (s == 20) i_decim = 8'd0;
            if (s == 60) chk("t2_notfull", {31'd0, o_full}, 32'd0);
            if (s == 61) chk("t2_full", {31'd0, o_full}, 32'd1);
        end
        @(negedge clock);
        i_valid = 1'b0;
        for (int n = 0; n < 16; n++) rd(n, 0, 16'(4 * n), 2000 + n);
        rd(15, 1, ch1(60), 2115);
        drain();

        // 3: abort after 5 writes, then restart from address 0
        start_run(0);
        for (int k = 0; k < 5; k++) feed(100 + k);
        @(negedge clock);
        i_run   = 1'b0;
        i_valid = 1'b1;
        i_data  = mk(999);
        @(negedge clock);
        i_valid = 1'b0;
        chk("t3_busy", {31'd0, o_busy}, 32'd0);
        chk("t3_full", {31'd0, o_full}, 32'd0);
        for (int k = 0; k < 5; k++) rd(k, 0, 16'(100 + k), 3000 + k);
        drain();
        @(negedge clock);
        i_run = 1'b1;
        feed(200);
        feed(201);
        @(negedge clock);
        i_valid = 1'b0;
        rd(0, 0, 16'd200, 3100);
        rd(1, 1, ch1(201), 3101);
        rd(2, 0, 16'd102, 3102);
        drain();
        chk("t3_busy_again", {31'd0, o_busy}, 32'd1);

        // 4: reset mid-capture clears outputs; later run is clean
        @(negedge clock);
        in_reset = 1'b1;
        i_run    = 1'b0;
        @(negedge clock);
        chk("t4_full", {31'd0, o_full}, 32'd0);
        chk("t4_busy", {31'd0, o_busy}, 32'd0);
        chk("t4_rdata", {16'd0, o_read_data}, 32'd0);
        in_reset = 1'b0;
        start_run(0);
        for (int s = 300; s < 316; s++) feed(s);
        @(negedge clock);
        i_valid = 1'b0;
        chk("t4_full_after", {31'd0, o_full}, 32'd1);
        rd(0, 0, 16'd300, 4000);
        rd(15, 1, ch1(315), 4115);
        drain();

`ifdef LOG_CAPTURE_TRIGGER_EN
        // 6: trigger at sample 10; busy while armed
        @(negedge clock);
        i_trigger = 1'b0;
        start_run(0);
        for (int s = 0; s < 31; s++) begin
            feed(s);
            i_trigger = (s == 10);
            if (s == 5)  chk("t6_busy_armed", {31'd0, o_busy}, 32'd1);
            if (s == 10) chk("t6_notfull", {31'd0, o_full}, 32'd0);
        end
        @(negedge clock);
        i_valid   = 1'b0;
        i_trigger = 1'b0;
        chk("t6_full", {31'd0, o_full}, 32'd1);
        rd(0, 0, 16'd10, 6000);
        rd(1, 0, 16'd11, 6001);
        rd(15, 1, ch1(25), 6115);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
